traffic_light_seq: RTL and testbench
====================================

// Module: traffic_light_seq
// PURPOSE
//  Downstream consumer of the programmable tick divider: counts its one-cycle
//  tick pulses to sequence a two-road traffic junction with pedestrian request
//  and night (flashing) mode. Outputs drive lamp/walk pins via uio_out at top.
//  All timing is in ticks, so phase lengths scale with the divider setting.
// PARAMETERS
//  T_MAIN_G  8'd8  main-road green length, ticks (>=1)
//  T_MIN_G   8'd3  minimum main green before a ped request may cut it (1..T_MAIN_G)
//  T_SIDE_G  8'd5  side-road green length, ticks (>=1)
//  T_YEL     8'd2  yellow length, both roads (>=1)
//  T_RED     8'd1  all-red clearance length (>=1)
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  async active-low reset
//  tick        in   1  one-clk pulse from divider, synchronous to clk
//  ped_req     in   1  pedestrian button, asynchronous level
//  night_mode  in   1  night-mode switch, asynchronous level
//  main_light  out  3  {red,yellow,green} main road, registered
//  side_light  out  3  {red,yellow,green} side road, registered
//  walk        out  1  pedestrian walk lamp, registered
//  state_code  out  3  current state encoding, registered
//  time_left   out  8  timer value (ticks remaining - 1) in current phase
// BEHAVIOUR
//  Clock/reset: one clock clk; reset rst_n asynchronous, active-low.
//  - ped_req, night_mode: 2-flop synchronisers; ped rising edge sets ped_pending.
//  States (state_code): 0 MAIN_G, 1 MAIN_Y, 2 RED_A, 3 SIDE_G, 4 SIDE_Y,
//    5 RED_B, 6 NIGHT. Codes 7 -> recover to RED_B next clk.
//  Timer: loaded with T_x-1 on entry; decrements on tick; on tick with timer==0
//    state advances, so each phase lasts exactly T_x ticks. No tick -> no change.
//  Sequence: MAIN_G->MAIN_Y->RED_A->SIDE_G->SIDE_Y->RED_B->MAIN_G.
//  Lamps: MAIN_G m=001 s=100; MAIN_Y m=010 s=100; RED_A/RED_B m=100 s=100;
//    SIDE_G m=100 s=001; SIDE_Y m=100 s=010.
//  Ped cut: in MAIN_G, on tick with ped_pending=1 and (T_MAIN_G-timer)>=T_MIN_G
//    -> MAIN_Y immediately (timer need not be 0).
//  walk=1 throughout SIDE_G iff ped_pending was 1 at SIDE_G entry;
//    ped_pending clears on SIDE_G entry. Edge in the same clk as entry is kept
//    pending for the next cycle.
//  Night: on expiring tick of RED_A or RED_B with night_sync=1 -> NIGHT
//    (instead of SIDE_G/MAIN_G). In NIGHT a blink bit toggles each tick
//    (starts 1 on entry): blink=1 m=010 s=100, blink=0 m=000 s=000; walk=0;
//    time_left=0. Exit on a tick with night_sync=0 -> RED_B (T_RED), then MAIN_G.
//    ped_pending is retained across NIGHT.
//  Simultaneous: tick and ped edge same clk -> edge counted from next clk.
//  Outputs update the clk after the state change (registered, 1-clk latency).
//  Reset (async, any time incl. mid-phase): state=RED_B, timer=T_RED-1,
//    main_light=100, side_light=100, walk=0, state_code=5, time_left=T_RED-1,
//    ped_pending=0, blink=0, synchronisers=0.
// TESTING (T_MAIN_G=8,T_MIN_G=3,T_SIDE_G=5,T_YEL=2,T_RED=1)
//  1 Reset, tick every 4 clk, inputs 0 -> RED_B 1 tick, MAIN_G 8, MAIN_Y 2,
//    RED_A 1, SIDE_G 5, SIDE_Y 2, RED_B 1; full cycle 19 ticks; walk stays 0.
//  2 ped_req pulse 1 tick into MAIN_G -> MAIN_Y after 3rd MAIN_G tick;
//    walk=1 for all 5 SIDE_G ticks, then 0; ped_pending=0.
//  3 ped_req pulse after 6 MAIN_G ticks -> MAIN_Y on the next tick (7th).
//  4 night_mode=1 during MAIN_G -> finishes to RED_A, then NIGHT; main_light
//    alternates 010/000 per tick; night_mode=0 -> RED_B 1 tick, then MAIN_G.
//  5 tick held 0 for 100 clk mid-SIDE_G -> state/time_left frozen.
//  6 rst_n low mid-SIDE_Y (asynchronous, no clk edge) -> outputs immediately
//    m=100 s=100 walk=0 state_code=5.

Source files
------------

// File: rtl/traffic_light_seq.sv
// traffic_light_seq
//   Two-road junction sequencer driven by one-cycle tick pulses from the
//   programmable divider. All phase lengths are counted in ticks. Supports a
//   pedestrian request (cuts main green short and lights walk during side
//   green) and a night mode (flashing main yellow, side dark).
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   tick        one-clk pulse, synchronous to clk
//   ped_req     pedestrian button, asynchronous level
//   night_mode  night switch, asynchronous level
//   main_light  {red,yellow,green} main road, registered
//   side_light  {red,yellow,green} side road, registered
//   walk        pedestrian walk lamp, registered
//   state_code  current state encoding, registered
//   time_left   ticks remaining minus one in current phase, registered
module traffic_light_seq #(
    parameter logic [7:0] T_MAIN_G = 8'd8,
    parameter logic [7:0] T_MIN_G  = 8'd3,
    parameter logic [7:0] T_SIDE_G = 8'd5,
    parameter logic [7:0] T_YEL    = 8'd2,
    parameter logic [7:0] T_RED    = 8'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic [2:0] state_code,
    output logic [7:0] time_left
);

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        RED_A  = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4,
        RED_B  = 3'd5,
        NIGHT  = 3'd6
    } state_t;

    state_t     state, nxt_state;
    logic [7:0] timer, nxt_timer;
    logic       blink, nxt_blink;
    logic       walk_flag, nxt_walk_flag;
    logic       ped_pending;
    logic       ped_s1, ped_s2, ped_s3;
    logic       night_s1, night_sync;
    logic       ped_edge;
    logic       side_entry;

    assign ped_edge = ped_s2 & ~ped_s3;

    always_comb begin
        nxt_state     = state;
        nxt_timer     = timer;
        nxt_blink     = blink;
        nxt_walk_flag = walk_flag;
        side_entry    = 1'b0;
        case (state)
            MAIN_G: if (tick) begin
                // Elapsed ticks including this one equal T_MAIN_G - timer.
                if (timer == '0 || (ped_pending && (T_MAIN_G - timer) >= T_MIN_G)) begin
                    nxt_state = MAIN_Y;
                    nxt_timer = T_YEL - 8'd1;
                end else begin
                    nxt_timer = timer - 8'd1;
                end
            end
            MAIN_Y: if (tick) begin
                if (timer == '0) begin
                    nxt_state = RED_A;
                    nxt_timer = T_RED - 8'd1;
                end else begin
                    nxt_timer = timer - 8'd1;
                end
            end
            RED_A: if (tick) begin
                if (timer == '0) begin
                    if (night_sync) begin
                        nxt_state = NIGHT;
                        nxt_timer = '0;
                        nxt_blink = 1'b1;
                    end else begin
                        nxt_state     = SIDE_G;
                        nxt_timer     = T_SIDE_G - 8'd1;
                        nxt_walk_flag = ped_pending;
                        side_entry    = 1'b1;
                    end
                end else begin
                    nxt_timer = timer - 8'd1;
                end
            end
            SIDE_G: if (tick) begin
                if (timer == '0) begin
                    nxt_state = SIDE_Y;
                    nxt_timer = T_YEL - 8'd1;
                end else begin
                    nxt_timer = timer - 8'd1;
                end
            end
            SIDE_Y: if (tick) begin
                if (timer == '0) begin
                    nxt_state = RED_B;
                    nxt_timer = T_RED - 8'd1;
                end else begin
                    nxt_timer = timer - 8'd1;
                end
            end
            RED_B: if (tick) begin
                if (timer == '0) begin
                    if (night_sync) begin
                        nxt_state = NIGHT;
                        nxt_timer = '0;
                        nxt_blink = 1'b1;
                    end else begin
                        nxt_state = MAIN_G;
                        nxt_timer = T_MAIN_G - 8'd1;
                    end
                end else begin
                    nxt_timer = timer - 8'd1;
                end
            end
            NIGHT: if (tick) begin
                if (!night_sync) begin
                    nxt_state = RED_B;
                    nxt_timer = T_RED - 8'd1;
                end else begin
                    nxt_blink = ~blink;
                end
            end
            default: begin
                // Unused code: fall back to all-red clearance without waiting for a tick.
                nxt_state = RED_B;
                nxt_timer = T_RED - 8'd1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RED_B;
            timer       <= T_RED - 8'd1;
            blink       <= 1'b0;
            walk_flag   <= 1'b0;
            ped_pending <= 1'b0;
            ped_s1      <= 1'b0;
            ped_s2      <= 1'b0;
            ped_s3      <= 1'b0;
            night_s1    <= 1'b0;
            night_sync  <= 1'b0;
            main_light  <= 3'b100;
            side_light  <= 3'b100;
            walk        <= 1'b0;
            state_code  <= 3'd5;
            time_left   <= T_RED - 8'd1;
        end else begin
            ped_s1     <= ped_req;
            ped_s2     <= ped_s1;
            ped_s3     <= ped_s2;
            night_s1   <= night_mode;
            night_sync <= night_s1;

            state     <= nxt_state;
            timer     <= nxt_timer;
            blink     <= nxt_blink;
            walk_flag <= nxt_walk_flag;
            // A new edge wins over the clear on side-green entry, so it is not lost.
            ped_pending <= ped_edge | (ped_pending & ~side_entry);

            // Outputs follow the current state, hence one clk behind it.
            case (state)
                MAIN_G:  begin main_light <= 3'b001; side_light <= 3'b100; end
                MAIN_Y:  begin main_light <= 3'b010; side_light <= 3'b100; end
                SIDE_G:  begin main_light <= 3'b100; side_light <= 3'b001; end
                SIDE_Y:  begin main_light <= 3'b100; side_light <= 3'b010; end
                NIGHT:   begin
                    main_light <= blink ? 3'b010 : 3'b000;
                    side_light <= blink ? 3'b100 : 3'b000;
                end
                default: begin main_light <= 3'b100; side_light <= 3'b100; end
            endcase
            walk       <= (state == SIDE_G) && walk_flag;
            state_code <= state;
            time_left  <= (state == NIGHT) ? '0 : timer;
        end
    end

endmodule

// File: tb/tb_traffic_light_seq.sv
module tb_traffic_light_seq;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       ped_req;
    logic       night_mode;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic [2:0] state_code;
    logic [7:0] time_left;

    traffic_light_seq #(
        .T_MAIN_G(8'd8),
        .T_MIN_G (8'd3),
        .T_SIDE_G(8'd5),
        .T_YEL   (8'd2),
        .T_RED   (8'd1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .ped_req   (ped_req),
        .night_mode(night_mode),
        .main_light(main_light),
        .side_light(side_light),
        .walk      (walk),
        .state_code(state_code),
        .time_left (time_left)
    );

    typedef struct {
        int code;
        int m;
        int s;
        int w;
        int tl;
        int dur;   // ticks the phase lasts; -1 = not checked
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int idx, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s (phase %0d): got %0d expected %0d", name, idx, act, expv);
        end
    endtask

    // Lamp codes as integers: 1 = green, 2 = yellow, 4 = red, 0 = dark.
    task automatic push_phase(input int code, input int dur, input int w);
        exp_t e;
        e.code = code; e.dur = dur; e.w = w;
        case (code)
            0: begin e.m = 1; e.s = 4; e.tl = 7; end
            1: begin e.m = 2; e.s = 4; e.tl = 1; end
            2: begin e.m = 4; e.s = 4; e.tl = 0; end
            3: begin e.m = 4; e.s = 1; e.tl = 4; end
            4: begin e.m = 4; e.s = 2; e.tl = 1; end
            default: begin e.m = 4; e.s = 4; e.tl = 0; end
        endcase
        exp_q.push_back(e);
    endtask

    task automatic push_night(input int blink_on);
        exp_t e;
        e.code = 6; e.w = 0; e.tl = 0; e.dur = 1;
        e.m = blink_on ? 2 : 0;
        e.s = blink_on ? 4 : 0;
        exp_q.push_back(e);
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (3) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    endtask

    task automatic ped_pulse();
        ped_req = 1'b1;
        repeat (2) @(posedge clk);
        #1 ped_req = 1'b0;
    endtask

    // Monitor: every change of the visible phase pops one expectation and
    // checks the previous phase's length in ticks.
    initial begin
        logic [9:0] sig, last_sig;
        bit   first     = 1;
        bit   have_prev = 0;
        int   tick_cnt  = 0;
        int   prev_dur  = 0;
        int   idx       = 0;
        exp_t e;
        last_sig = '0;
        forever begin
            @(negedge clk);
            if (done) break;
            sig = {state_code, main_light, side_light, walk};
            if (first || sig != last_sig) begin
                if (have_prev && prev_dur >= 0)
                    chk("duration", idx - 1, tick_cnt, prev_dur);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_change: got state_code %0d, no phase expected", state_code);
                    have_prev = 0;
                end else begin
                    e = exp_q.pop_front();
                    chk("state_code", idx, int'(state_code), e.code);
                    chk("main_light", idx, int'(main_light), e.m);
                    chk("side_light", idx, int'(side_light), e.s);
                    chk("walk",       idx, int'(walk),       e.w);
                    chk("time_left",  idx, int'(time_left),  e.tl);
                    prev_dur  = e.dur;
                    have_prev = 1;
                end
                idx++;
                tick_cnt = 0;
                last_sig = sig;
                first    = 0;
            end
            if (tick) tick_cnt++;
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: got no end of stimulus expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        tick       = 1'b0;
        ped_req    = 1'b0;
        night_mode = 1'b0;
        rst_n      = 1'b1;

        // Normal cycle, no requests
        push_phase(5, 1, 0);
        push_phase(0, 8, 0);
        push_phase(1, 2, 0);
        push_phase(2, 1, 0);
        push_phase(3, 5, 0);
        push_phase(4, 2, 0);
        push_phase(5, 1, 0);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        do_ticks(20);

        // Ped request one tick into main green: cut after 3rd tick
        push_phase(0, 3, 0);
        push_phase(1, 2, 0);
        push_phase(2, 1, 0);
        push_phase(3, 5, 1);
        push_phase(4, 2, 0);
        push_phase(5, 1, 0);
        do_ticks(1);
        ped_pulse();
        do_ticks(13);

        // Ped request after 6 ticks: cut on the 7th
        push_phase(0, 7, 0);
        push_phase(1, 2, 0);
        push_phase(2, 1, 0);
        push_phase(3, 5, 1);
        push_phase(4, 2, 0);
        push_phase(5, 1, 0);
        do_ticks(6);
        ped_pulse();
        do_ticks(12);

        // Night mode: full main green (no stale ped), then flashing
        push_phase(0, 8, 0);
        push_phase(1, 2, 0);
        push_phase(2, 1, 0);
        push_night(1);
        push_night(0);
        push_night(1);
        push_night(0);
        push_phase(5, 1, 0);
        do_ticks(2);
        night_mode = 1'b1;
        do_ticks(12);
        night_mode = 1'b0;
        do_ticks(2);

        // Tick stall mid side green, then async reset mid side yellow
        push_phase(0, 8, 0);
        push_phase(1, 2, 0);
        push_phase(2, 1, 0);
        push_phase(3, 5, 0);
        push_phase(4, -1, 0);
        push_phase(5, 1, 0);
        push_phase(0, -1, 0);
        do_ticks(11);
        do_ticks(2);
        repeat (100) @(posedge clk);
        #1;
        chk("frozen_state_code", -1, int'(state_code), 3);
        chk("frozen_time_left",  -1, int'(time_left),  2);
        do_ticks(3);
        do_ticks(1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_main_light", -1, int'(main_light), 4);
        chk("async_rst_side_light", -1, int'(side_light), 4);
        chk("async_rst_walk",       -1, int'(walk),       0);
        chk("async_rst_state_code", -1, int'(state_code), 5);
        chk("async_rst_time_left",  -1, int'(time_left),  0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        do_ticks(1);
        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", -1, exp_q.size(), 0);
        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
